// File: rtl/mux_adc_sampler.sv
// mux_adc_sampler
// Scan sequencer and serial ADC front end for the analog multiplexer chain.
// For each channel it pulses switch_signal to advance the mux, waits for the
// analog input to settle, and clocks one 16-bit frame out of the ADC. The
// result is presented with its channel tag in a single-entry valid/ready
// output register.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-low reset
//   enable              run the scan continuously while high
//   switch_signal       channel-advance pulse to the mux switcher
//   adc_cs_n            ADC chip select, active-low
//   adc_sclk            ADC serial clock, idles low
//   adc_miso            ADC serial data, MSB first
//   sample_data         conversion result (last ADC_BITS bits of the frame)
//   sample_ch           channel tag of sample_data
//   sample_frame_start  high with a sample whose tag is 0
//   sample_valid        output register holds an unaccepted sample
//   sample_ready        consumer accepts when valid and ready are both high
//   overrun             sticky; a sample was dropped
//   busy                sequencer is not idle
module mux_adc_sampler #(
  parameter int unsigned NUM_CH      = 18,
  parameter int unsigned SWITCH_HIGH = 4,
  parameter int unsigned SETTLE      = 64,
  parameter int unsigned SCLK_DIV    = 4,
  parameter int unsigned ADC_BITS    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                switch_signal,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_miso,
  output logic [ADC_BITS-1:0] sample_data,
  output logic [4:0]          sample_ch,
  output logic                sample_frame_start,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned TMAX = (SWITCH_HIGH > SETTLE) ? SWITCH_HIGH : SETTLE;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam int unsigned DW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_SETTLE,
    ST_CONVERT,
    ST_DELIVER
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0]       tmr;
  logic [DW-1:0]       div_cnt;
  logic [3:0]          bit_cnt;
  logic [ADC_BITS-1:0] shift;
  logic [4:0]          ch_cnt;

  logic sw_done;
  logic st_done;
  logic half_end;
  logic conv_done;

  always_comb begin
    sw_done   = (tmr == TW'(SWITCH_HIGH - 1));
    st_done   = (tmr == TW'(SETTLE - 1));
    half_end  = (div_cnt == DW'(SCLK_DIV - 1));
    conv_done = half_end && adc_sclk && (bit_cnt == 4'd15);

    state_nx = state;
    case (state)
      ST_IDLE:    if (enable)    state_nx = ST_SWITCH;
      ST_SWITCH:  if (sw_done)   state_nx = ST_SETTLE;
      ST_SETTLE:  if (st_done)   state_nx = ST_CONVERT;
      ST_CONVERT: if (conv_done) state_nx = ST_DELIVER;
      ST_DELIVER: state_nx = enable ? ST_SWITCH : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Strobe outputs are registered copies of the next-state decode, so they
  // line up with the state register and are free of decode glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      switch_signal      <= 1'b0;
      adc_cs_n           <= 1'b1;
      adc_sclk           <= 1'b0;
      busy               <= 1'b0;
      tmr                <= '0;
      div_cnt            <= '0;
      bit_cnt            <= '0;
      shift              <= '0;
      ch_cnt             <= '0;
      sample_data        <= '0;
      sample_ch          <= '0;
      sample_frame_start <= 1'b0;
      sample_valid       <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      switch_signal <= (state_nx == ST_SWITCH);
      adc_cs_n      <= (state_nx != ST_CONVERT);
      busy          <= (state_nx != ST_IDLE);

      if ((state_nx != state) || !((state == ST_SWITCH) || (state == ST_SETTLE))) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + TW'(1);
      end

      // Each bit is SCLK_DIV clocks low then SCLK_DIV clocks high; data is
      // taken on the edge that drops sclk. The shifter is only ADC_BITS wide,
      // so after 16 shifts it holds exactly the trailing ADC_BITS bits.
      if (state == ST_CONVERT) begin
        if (half_end) begin
          div_cnt  <= '0;
          adc_sclk <= ~adc_sclk;
          if (adc_sclk) begin
            shift   <= {shift[ADC_BITS-2:0], adc_miso};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end else begin
        div_cnt  <= '0;
        adc_sclk <= 1'b0;
        bit_cnt  <= '0;
      end

      if (state == ST_DELIVER) begin
        ch_cnt <= (ch_cnt == 5'(NUM_CH - 1)) ? '0 : ch_cnt + 5'd1;
        if (!sample_valid || sample_ready) begin
          sample_data        <= shift;
          sample_ch          <= ch_cnt;
          sample_frame_start <= (ch_cnt == '0);
          sample_valid       <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_adc_sampler.sv
// Testbench for mux_adc_sampler with default parameters.
// Drives a serial ADC model, checks reset values, SPI framing and timing,
// channel tagging and wrap, backpressure/overrun, accept-in-DELIVER,
// enable drop and asynchronous reset during a conversion.
module tb_mux_adc_sampler;

  localparam int SCLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        switch_signal;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_miso;
  logic [11:0] sample_data;
  logic [4:0]  sample_ch;
  logic        sample_frame_start;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overrun;
  logic        busy;

  mux_adc_sampler dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .switch_signal      (switch_signal),
    .adc_cs_n           (adc_cs_n),
    .adc_sclk           (adc_sclk),
    .adc_miso           (adc_miso),
    .sample_data        (sample_data),
    .sample_ch          (sample_ch),
    .sample_frame_start (sample_frame_start),
    .sample_valid       (sample_valid),
    .sample_ready       (sample_ready),
    .overrun            (overrun),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: MSB presented when chip select falls, next bit after each
  // sclk falling edge.
  logic [15:0] adc_word = 16'h0000;
  int          bitidx = 15;
  always @(negedge adc_cs_n) bitidx <= 15;
  always @(negedge adc_sclk) bitidx <= bitidx - 1;
  always_comb adc_miso = (!adc_cs_n && bitidx >= 0 && bitidx <= 15) ? adc_word[bitidx[3:0]] : 1'b0;

  // Bus monitor: switch pulse count, sclk pulse count per frame, sclk phase
  // widths and chip-select low duration.
  logic sw_prev = 1'b0, cs_prev = 1'b1, sclk_prev = 1'b0;
  int   sw_pulses = 0, sclk_cnt = 0, run = 0, cs_len = 0, width_err = 0, cs_len_err = 0;
  always @(negedge clk) begin
    sw_prev   <= switch_signal;
    cs_prev   <= adc_cs_n;
    sclk_prev <= adc_sclk;
    if (switch_signal && !sw_prev) sw_pulses <= sw_pulses + 1;
    if (!adc_cs_n) begin
      cs_len <= cs_prev ? 1 : cs_len + 1;
      if (cs_prev) sclk_cnt <= 0;
      else if (adc_sclk && !sclk_prev) sclk_cnt <= sclk_cnt + 1;
      if (!cs_prev && adc_sclk == sclk_prev) run <= run + 1;
      else begin
        if (!cs_prev && run != SCLK_DIV) width_err <= width_err + 1;
        run <= 1;
      end
    end else if (!cs_prev) begin
      if (run != SCLK_DIV) width_err <= width_err + 1;
      if (cs_len != 32 * SCLK_DIV) cs_len_err <= cs_len_err + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return switch_signal;
      1:       return adc_cs_n;
      2:       return sample_valid;
      3:       return busy;
      default: return adc_sclk;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int limit, input string what,
                          output int t);
    t = -1;
    for (int k = 0; k <= limit; k++) begin
      if (sig(sel) == lvl) begin
        t = cyc;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL timeout %s: got no event, required within %0d cycles", what, limit);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [4:0]  ch;
    logic [11:0] data;
    logic        fs;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int t, t0, trel, tprev, seen;

    tbl[0]  = '{16'h0ABC, 5'd0,  12'hABC, 1'b1};
    tbl[1]  = '{16'hF123, 5'd1,  12'h123, 1'b0};
    tbl[2]  = '{16'h8FFF, 5'd2,  12'hFFF, 1'b0};
    tbl[3]  = '{16'h7000, 5'd3,  12'h000, 1'b0};
    tbl[4]  = '{16'h1555, 5'd4,  12'h555, 1'b0};
    tbl[5]  = '{16'h2AAA, 5'd5,  12'hAAA, 1'b0};
    tbl[6]  = '{16'h3800, 5'd6,  12'h800, 1'b0};
    tbl[7]  = '{16'h4001, 5'd7,  12'h001, 1'b0};
    tbl[8]  = '{16'hC3C3, 5'd8,  12'h3C3, 1'b0};
    tbl[9]  = '{16'h5A5A, 5'd9,  12'hA5A, 1'b0};
    tbl[10] = '{16'h6F0F, 5'd10, 12'hF0F, 1'b0};
    tbl[11] = '{16'h9246, 5'd11, 12'h246, 1'b0};
    tbl[12] = '{16'hA8AC, 5'd12, 12'h8AC, 1'b0};
    tbl[13] = '{16'hB135, 5'd13, 12'h135, 1'b0};
    tbl[14] = '{16'hD7E9, 5'd14, 12'h7E9, 1'b0};
    tbl[15] = '{16'hE7FF, 5'd15, 12'h7FF, 1'b0};
    tbl[16] = '{16'h0F00, 5'd16, 12'hF00, 1'b0};
    tbl[17] = '{16'hFFFF, 5'd17, 12'hFFF, 1'b0};
    tbl[18] = '{16'h1234, 5'd0,  12'h234, 1'b1};
    tbl[19] = '{16'h4321, 5'd1,  12'h321, 1'b0};

    // Reset held with enable high: every output at its reset value.
    repeat (3) tick();
    check("reset_outputs",
          32'({switch_signal, adc_cs_n, adc_sclk, sample_data, sample_ch,
               sample_frame_start, sample_valid, overrun, busy}),
          32'({1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}));

    // Release: first-channel timing and SPI framing.
    adc_word = tbl[0].word;
    trel = cyc;
    reset = 1'b1;
    wait_for(0, 1'b1, 10, "switch_rise", t0);
    check("switch_rise_delay", t0 - trel, 1);
    wait_for(0, 1'b0, 10, "switch_fall", t);
    check("switch_width", t - t0, 4);
    wait_for(1, 1'b0, 100, "cs_fall", t);
    check("cs_fall_delay", t - t0, 68);
    wait_for(2, 1'b1, 300, "valid_rise", t);
    check("valid_delay", t - t0, 197);
    check("sclk_pulses", sclk_cnt, 16);
    check("sclk_width_errs", width_err, 0);
    check("cs_len_errs", cs_len_err, 0);
    check("data_0", 32'(sample_data), 32'(tbl[0].data));
    check("ch_0", 32'(sample_ch), 32'(tbl[0].ch));
    check("fs_0", 32'(sample_frame_start), 32'(tbl[0].fs));
    tprev = t;

    // Continuous scan through the wrap; enable dropped while the 20th
    // channel is in its switch pulse so exactly 20 channels run.
    for (int i = 1; i < 20; i++) begin
      adc_word = tbl[i].word;
      if (i == 19) enable = 1'b0;
      wait_for(2, 1'b0, 5, "valid_clear", t);
      wait_for(2, 1'b1, 400, "valid_rise", t);
      check("period", t - tprev, 197);
      check("data", 32'(sample_data), 32'(tbl[i].data));
      check("ch", 32'(sample_ch), 32'(tbl[i].ch));
      check("frame_start", 32'(sample_frame_start), 32'(tbl[i].fs));
      tprev = t;
    end
    check("busy_after_last", 32'(busy), 0);
    repeat (20) tick();
    check("switch_pulses", sw_pulses, 20);
    check("idle_busy", 32'(busy), 0);
    check("idle_switch", 32'(switch_signal), 0);
    check("no_overrun_ready_high", 32'(overrun), 0);
    check("scan_width_errs", width_err, 0);
    check("scan_cs_len_errs", cs_len_err, 0);

    // Backpressure: tag 0 held, tag 1 dropped, next delivered is tag 2.
    reset = 1'b0;
    sample_ready = 1'b0;
    tick();
    reset = 1'b1;
    enable = 1'b1;
    adc_word = 16'h1234;
    wait_for(2, 1'b1, 400, "bp_valid0", t);
    check("bp_data0", 32'(sample_data), 'h234);
    check("bp_ch0", 32'(sample_ch), 0);
    adc_word = 16'h5678;
    wait_for(1, 1'b0, 250, "bp_cs_fall1", t);
    wait_for(1, 1'b1, 200, "bp_cs_rise1", t);
    tick();
    check("bp_overrun", 32'(overrun), 1);
    check("bp_held_valid", 32'(sample_valid), 1);
    check("bp_held_data", 32'(sample_data), 'h234);
    check("bp_held_ch", 32'(sample_ch), 0);
    adc_word = 16'h9DEF;
    repeat (10) tick();
    check("bp_still_held", 32'({sample_data, sample_ch}), 32'({12'h234, 5'd0}));
    sample_ready = 1'b1;
    tick();
    check("bp_accept_clears", 32'(sample_valid), 0);
    wait_for(2, 1'b1, 300, "bp_valid2", t);
    check("bp_next_ch", 32'(sample_ch), 2);
    check("bp_next_data", 32'(sample_data), 'hDEF);
    check("bp_overrun_sticky", 32'(overrun), 1);

    // Accept exactly in the DELIVER cycle: new sample loads, no overrun.
    reset = 1'b0;
    sample_ready = 1'b0;
    tick();
    check("rst_clears_overrun", 32'(overrun), 0);
    reset = 1'b1;
    adc_word = 16'h0111;
    wait_for(2, 1'b1, 400, "ad_valid0", t);
    check("ad_data0", 32'(sample_data), 'h111);
    adc_word = 16'h0222;
    wait_for(1, 1'b0, 250, "ad_cs_fall1", t);
    wait_for(1, 1'b1, 200, "ad_cs_rise1", t);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    check("ad_valid", 32'(sample_valid), 1);
    check("ad_ch", 32'(sample_ch), 1);
    check("ad_data", 32'(sample_data), 'h222);
    check("ad_no_overrun", 32'(overrun), 0);
    adc_word = 16'h0333;
    sample_ready = 1'b1;
    tick();
    check("ad_drain", 32'(sample_valid), 0);
    check("ad_no_overrun2", 32'(overrun), 0);

    // Enable dropped during SETTLE of channel 5.
    seen = -1;
    for (int n = 0; n < 6; n++) begin
      wait_for(2, 1'b0, 5, "en_valid_clear", t);
      wait_for(2, 1'b1, 400, "en_valid_rise", t);
      seen = int'(sample_ch);
      if (seen == 4) break;
    end
    check("reach_ch4", seen, 4);
    wait_for(0, 1'b0, 10, "en_switch_fall", t);
    enable = 1'b0;
    wait_for(2, 1'b0, 5, "en_valid_clear5", t);
    wait_for(2, 1'b1, 400, "en_valid5", t);
    check("en_ch5_delivered", 32'(sample_ch), 5);
    check("en_busy_drop", 32'(busy), 0);
    repeat (30) tick();
    check("en_idle", 32'({busy, switch_signal, adc_cs_n, sample_valid}), 32'(4'b0010));
    enable = 1'b1;
    wait_for(2, 1'b1, 400, "en_valid6", t);
    check("en_next_ch6", 32'(sample_ch), 6);

    // Asynchronous reset in the middle of a conversion.
    wait_for(1, 1'b0, 300, "rst_cs_fall", t);
    wait_for(4, 1'b1, 20, "rst_sclk_high", t);
    check("pre_reset_spi", 32'({adc_cs_n, adc_sclk}), 32'(2'b01));
    reset = 1'b0;
    #1;
    check("async_reset_spi", 32'({adc_cs_n, adc_sclk}), 32'(2'b10));
    check("async_reset_state", 32'({busy, sample_valid, sample_ch}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_adc_sampler.md
# mux_adc_sampler

Scan sequencer and ADC front end for the analog multiplexer chain. Issues the `switch_signal` pulse that advances the mux switcher to its next channel, waits for analog settling, and reads one conversion from a 16-bit-frame serial ADC. Presents the result, tagged with its channel number, on a single-entry valid/ready output register for the telemetry framer.

## Interface

**Parameters**
- `NUM_CH`, default 18: channels per scan; channel tag wraps from `NUM_CH-1` to 0.
- `SWITCH_HIGH`, default 4: width of the `switch_signal` pulse, in clk cycles (≥2).
- `SETTLE`, default 64: clk cycles between the pulse falling and the start of conversion (≥1).
- `SCLK_DIV`, default 4: clk cycles per `adc_sclk` half-period (≥1).
- `ADC_BITS`, default 12: result width, taken from the last `ADC_BITS` bits of the 16-bit frame.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: run the scan continuously while high.
- `switch_signal` out 1: channel-advance pulse to the mux switcher.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_sclk` out 1: ADC serial clock; idles low.
- `adc_miso` in 1: ADC serial data, MSB first.
- `sample_data` out `ADC_BITS`: conversion result.
- `sample_ch` out 5: channel tag for `sample_data`.
- `sample_frame_start` out 1: high with a sample whose `sample_ch`==0.
- `sample_valid` out 1: output register holds an unaccepted sample.
- `sample_ready` in 1: consumer accepts the sample when both valid and ready are high.
- `overrun` out 1: sticky; a sample was dropped.
- `busy` out 1: FSM is not in IDLE.

## Operation

- **Reset values:** `switch_signal`=0, `adc_cs_n`=1, `adc_sclk`=0, `sample_data`=0, `sample_ch`=0, `sample_frame_start`=0, `sample_valid`=0, `overrun`=0, `busy`=0, FSM=IDLE, channel counter=0, all timers=0.
- **FSM states:** IDLE → SWITCH → SETTLE → CONVERT → DELIVER → (SWITCH if `enable`, else IDLE).
- **IDLE:** when `enable`=1, go to SWITCH on the next clock.
- **SWITCH:** `switch_signal`=1 for exactly `SWITCH_HIGH` cycles, then go to SETTLE.
- **SETTLE:** `switch_signal`=0 for exactly `SETTLE` cycles, then go to CONVERT.
- **CONVERT:**
  - `adc_cs_n`=0 for exactly `32*SCLK_DIV` cycles.
  - `adc_sclk` is low for the first `SCLK_DIV` cycles of each bit, then high for `SCLK_DIV` cycles; 16 bits total.
  - `adc_miso` is sampled on the clk edge that ends each high phase and shifted in MSB first.
  - Go to DELIVER with `adc_cs_n`=1 and `adc_sclk`=0.
- **DELIVER (1 cycle):**
  - Load `sample_data` = shift[`ADC_BITS`-1:0], `sample_ch` = channel counter, and `sample_frame_start` = (counter==0). Set `sample_valid`.
  - Increment the channel counter mod `NUM_CH`.
  - If `sample_valid`=1 and `sample_ready`=0 in this cycle, keep the old sample, discard the new one, and set `overrun`. The counter still increments.
  - If `sample_valid`=1 and `sample_ready`=1 in the same cycle, load the new sample with no overrun.
- **Output handshake:**
  - `sample_valid` stays high, with data held stable, until the consumer accepts.
  - On acceptance outside DELIVER, `sample_valid` clears next cycle.
- **enable:** deasserting `enable` mid-channel finishes the current channel through DELIVER, then goes to IDLE. The channel counter is never cleared except by reset, which keeps the tags aligned with the mux position.
- **overrun:** cleared only by reset.
- **Reset mid-operation:** all outputs take their reset values immediately (asynchronous). Any SPI transfer in progress is abandoned with `adc_cs_n` forced high.

## Timing

- `switch_signal` rises on the first clock after IDLE→SWITCH.
- `sample_valid` rises `SWITCH_HIGH + SETTLE + 32*SCLK_DIV + 1` cycles after `switch_signal` rises. This is 197 cycles with the defaults.
- Channel period while continuously enabled is `SWITCH_HIGH + SETTLE + 32*SCLK_DIV + 1` cycles. This is 197 cycles with the defaults, so a full scan takes 3546 cycles.
- `adc_cs_n` falls exactly `SWITCH_HIGH + SETTLE` cycles after `switch_signal` rises.
- A consumer that holds `sample_ready`=1 never causes an overrun.

## Test plan

- **Reset behaviour:** reset low with `enable`=1, then release reset → every output at its reset value during reset. `switch_signal` rises one cycle after release, high for 4 cycles; `adc_cs_n` falls 68 cycles after the rise.
- **SPI framing:** ADC model drives 0x0ABC, `sample_ready`=1 → exactly 16 `adc_sclk` pulses, each 4 high/4 low. `sample_data`=0xABC, `sample_ch`=0, `sample_frame_start`=1, `sample_valid` 197 cycles after the `switch_signal` rise.
- **Channel wrap:** 20 channels continuous, `sample_ready`=1 → tags 0..17 then 0, 1. `sample_frame_start` high only on tag 0. Exactly 20 `switch_signal` pulses.
- **Backpressure:** `sample_ready`=0 for two channel periods, then 1 → the first sample is held unchanged and the second is dropped. `overrun`=1 and stays 1. The next sample delivered carries tag 2.
- **Accept during DELIVER:** `sample_ready` pulses in exactly the DELIVER cycle while valid → the new sample is loaded, `overrun` stays 0.
- **Enable drop and mid-conversion reset:** drop `enable` during SETTLE of channel 5 → channel 5 is delivered, then IDLE with `busy`=0. Re-enable → next tag is 6. Assert reset mid-CONVERT → `adc_cs_n`=1 and `adc_sclk`=0 immediately.
